// File: rtl/rr_arb4_if.sv
// Request/grant bundle between requesters (master) and the 4-way arbiter (slave).
interface rr_arb4_if;
    logic [3:0] REQ;
    logic [3:0] GNT;
    logic [1:0] GIDX;
    logic       BUSY;

    modport master (output REQ, input GNT, GIDX, BUSY);
    modport slave  (input REQ, output GNT, GIDX, BUSY);
endinterface

// File: rtl/rr_arb4.sv
// 4-way round-robin arbiter, grant held while owner requests; 1-cycle REQ->GNT, registered outputs.
// Optional hold-limit release compiled in with RR_ARB4_TIMEOUT_EN (MAX_HOLD cycles, then one idle cycle).
module rr_arb4 #(
    parameter int MAX_HOLD = 8
) (
    input  logic     CLK,
    input  logic     RST,
    rr_arb4_if.slave bus
);
`ifdef RR_ARB4_TIMEOUT_EN
    typedef enum logic [1:0] {IDLE = 2'd0, GRANT = 2'd1, RELEASE = 2'd2} state_t;
    localparam logic [3:0] HOLD_LAST = 4'(MAX_HOLD - 1);
    logic [3:0] hold_q;
`else
    typedef enum logic [1:0] {IDLE = 2'd0, GRANT = 2'd1} state_t;
`endif

    state_t     state_q;
    logic [1:0] ptr_q;
    logic [3:0] gnt_q;
    logic [1:0] gidx_q;
    logic       busy_q;

    logic [1:0] base;
    logic [1:0] win_idx;
    logic       win_vld;
    logic [3:0] win_oh;

    // On a handoff the departing owner becomes the pointer at the same edge,
    // so the search must already start from it rather than from ptr_q.
    always_comb begin
        base    = (state_q == GRANT) ? gidx_q : ptr_q;
        win_idx = base;
        for (int k = 4; k >= 1; k--) begin
            if (bus.REQ[base + 2'(k)]) win_idx = base + 2'(k);
        end
    end

    assign win_vld = |bus.REQ;
    assign win_oh  = 4'b0001 << win_idx;

    always_ff @(posedge CLK or posedge RST) begin
        if (RST) begin
            state_q <= IDLE;
            ptr_q   <= 2'b11;
            gnt_q   <= 4'b0000;
            gidx_q  <= 2'b00;
            busy_q  <= 1'b0;
`ifdef RR_ARB4_TIMEOUT_EN
            hold_q  <= 4'd0;
`endif
        end else begin
            case (state_q)
                GRANT: begin
                    if (!bus.REQ[gidx_q]) begin
                        ptr_q <= gidx_q;
                        if (win_vld) begin
                            gnt_q  <= win_oh;
                            gidx_q <= win_idx;
                            busy_q <= 1'b1;
`ifdef RR_ARB4_TIMEOUT_EN
                            hold_q <= 4'd0;
`endif
                        end else begin
                            state_q <= IDLE;
                            gnt_q   <= 4'b0000;
                            busy_q  <= 1'b0;
                        end
                    end
`ifdef RR_ARB4_TIMEOUT_EN
                    else if (hold_q == HOLD_LAST) begin
                        state_q <= RELEASE;
                        ptr_q   <= gidx_q;
                        gnt_q   <= 4'b0000;
                        busy_q  <= 1'b0;
                    end else begin
                        hold_q <= hold_q + 4'd1;
                    end
`endif
                end
                default: begin
                    if (win_vld) begin
                        state_q <= GRANT;
                        gnt_q   <= win_oh;
                        gidx_q  <= win_idx;
                        busy_q  <= 1'b1;
`ifdef RR_ARB4_TIMEOUT_EN
                        hold_q  <= 4'd0;
`endif
                    end else begin
                        state_q <= IDLE;
                        gnt_q   <= 4'b0000;
                        busy_q  <= 1'b0;
                    end
                end
            endcase
        end
    end

    assign bus.GNT  = gnt_q;
    assign bus.GIDX = gidx_q;
    assign bus.BUSY = busy_q;
endmodule

// File: tb/tb_rr_arb4.sv
// Bench for rr_arb4: directed scenarios plus random request traffic against a rotational-priority model.
module tb_rr_arb4;
    localparam int TB_MAX_HOLD = 4;

    logic CLK;
    logic RST;
    rr_arb4_if bus();

    rr_arb4 #(.MAX_HOLD(TB_MAX_HOLD)) dut (
        .CLK (CLK),
        .RST (RST),
        .bus (bus)
    );

    initial CLK = 1'b0;
    always #5 CLK = ~CLK;

    int total = 0;
    int bad   = 0;

    // Reference: current owner (-1 = nobody), last owner pointer, cycles owned.
    int m_owner;
    int m_ptr;
    int m_held;

    function automatic int pick(input logic [3:0] r, input int p);
        for (int k = 1; k <= 4; k++) begin
            if (r[(p + k) % 4]) return (p + k) % 4;
        end
        return -1;
    endfunction

    task automatic model_reset();
        m_owner = -1;
        m_ptr   = 3;
        m_held  = 0;
    endtask

    task automatic model_step(input logic [3:0] r);
        if (m_owner < 0) begin
            m_owner = pick(r, m_ptr);
            m_held  = 1;
        end else if (!r[m_owner]) begin
            m_ptr   = m_owner;
            m_owner = pick(r, m_ptr);
            m_held  = 1;
        end
`ifdef RR_ARB4_TIMEOUT_EN
        else if (m_held == TB_MAX_HOLD) begin
            m_ptr   = m_owner;
            m_owner = -1;
        end
`endif
        else begin
            m_held = m_held + 1;
        end
    endtask

    function automatic logic [6:0] exp_f();
        if (m_owner < 0) return 7'b0;
        return {4'(1 << m_owner), 1'b1, 2'(m_owner)};
    endfunction

    function automatic logic [6:0] obs_f();
        return {bus.GNT, bus.BUSY, (bus.BUSY ? bus.GIDX : 2'b00)};
    endfunction

    // Called at a negedge; returns at the following negedge.
    task automatic step(input logic [3:0] r);
        bus.REQ = r;
        @(posedge CLK);
        model_step(r);
        @(negedge CLK);
    endtask

    task automatic test_reset();
        RST = 1'b1;
        bus.REQ = 4'b1111;
        model_reset();
        repeat (3) @(negedge CLK);
        total++;
        if ({bus.GNT, bus.BUSY, bus.GIDX} !== 7'b0000_0_00) begin
            $display("FAIL reset_state: got gnt/busy/gidx=%b want 0000000", {bus.GNT, bus.BUSY, bus.GIDX});
            bad++;
        end
        RST = 1'b0;
        step(4'b1111);
        total++;
        if ({bus.GNT, bus.BUSY, bus.GIDX} !== 7'b0001_1_00) begin
            $display("FAIL reset_first_grant: got %b want 0001100", {bus.GNT, bus.BUSY, bus.GIDX});
            bad++;
        end
        total++;
        if (obs_f() !== exp_f()) begin
            $display("FAIL reset_model: got %b want %b", obs_f(), exp_f());
            bad++;
        end
    endtask

    task automatic test_rotation();
        logic [3:0] drops [4];
        logic [3:0] want  [4];
        drops = '{4'b1110, 4'b1101, 4'b1011, 4'b0111};
        want  = '{4'b0010, 4'b0100, 4'b1000, 4'b0001};
        for (int i = 0; i < 4; i++) begin
            step(drops[i]);
            total++;
            if (bus.GNT !== want[i] || bus.BUSY !== 1'b1) begin
                $display("FAIL rotation_%0d: got gnt=%b busy=%b want gnt=%b busy=1", i, bus.GNT, bus.BUSY, want[i]);
                bad++;
            end
            total++;
            if (obs_f() !== exp_f()) begin
                $display("FAIL rotation_model_%0d: got %b want %b", i, obs_f(), exp_f());
                bad++;
            end
            step(4'b1111);
        end
    endtask

`ifndef RR_ARB4_TIMEOUT_EN
    task automatic test_hold();
        for (int i = 0; i < 20; i++) begin
            step(4'b0100);
            total++;
            if ({bus.GNT, bus.BUSY, bus.GIDX} !== 7'b0100_1_10) begin
                $display("FAIL hold_%0d: got %b want 0100110", i, {bus.GNT, bus.BUSY, bus.GIDX});
                bad++;
            end
        end
        step(4'b0000);
        total++;
        if (bus.GNT !== 4'b0000 || bus.BUSY !== 1'b0) begin
            $display("FAIL hold_release: got gnt=%b busy=%b want 0000/0", bus.GNT, bus.BUSY);
            bad++;
        end
    endtask
`endif

    task automatic test_fairness();
        step(4'b0000);
        model_reset();
        RST = 1'b1;
        @(negedge CLK);
        RST = 1'b0;
        step(4'b0010);
        step(4'b1010);
        total++;
        if (bus.GNT !== 4'b0010) begin
            $display("FAIL fair_setup: got gnt=%b want 0010", bus.GNT);
            bad++;
        end
        step(4'b1000);
        total++;
        if (bus.GNT !== 4'b1000) begin
            $display("FAIL fair_handoff: got gnt=%b want 1000", bus.GNT);
            bad++;
        end
        step(4'b1010);
        total++;
        if (bus.GNT !== 4'b1000) begin
            $display("FAIL fair_no_jump: got gnt=%b want 1000", bus.GNT);
            bad++;
        end
        step(4'b0010);
        total++;
        if (bus.GNT !== 4'b0010 || obs_f() !== exp_f()) begin
            $display("FAIL fair_regrant: got %b want %b", obs_f(), exp_f());
            bad++;
        end
    endtask

    task automatic test_async_reset();
        #2;
        RST = 1'b1;
        #1;
        total++;
        if (bus.GNT !== 4'b0000 || bus.BUSY !== 1'b0) begin
            $display("FAIL async_reset: got gnt=%b busy=%b want 0000/0", bus.GNT, bus.BUSY);
            bad++;
        end
        @(negedge CLK);
        RST = 1'b0;
        model_reset();
        step(4'b0010);
        total++;
        if (obs_f() !== exp_f()) begin
            $display("FAIL async_after: got %b want %b", obs_f(), exp_f());
            bad++;
        end
    endtask

`ifdef RR_ARB4_TIMEOUT_EN
    task automatic test_timeout();
        logic [3:0] want [9];
        want = '{4'b0001, 4'b0001, 4'b0001, 4'b0001, 4'b0000,
                 4'b0010, 4'b0010, 4'b0010, 4'b0010};
        step(4'b0000);
        RST = 1'b1;
        model_reset();
        @(negedge CLK);
        RST = 1'b0;
        for (int i = 0; i < 9; i++) begin
            step(4'b0011);
            total++;
            if (bus.GNT !== want[i]) begin
                $display("FAIL timeout_%0d: got gnt=%b want %b", i, bus.GNT, want[i]);
                bad++;
            end
        end
    endtask
`endif

    task automatic test_random();
        logic [3:0] r;
        r = 4'b0000;
        for (int i = 0; i < 400; i++) begin
            r = r ^ (4'($urandom_range(0, 15)) & 4'($urandom_range(0, 15)));
            step(r);
            total++;
            if (obs_f() !== exp_f()) begin
                $display("FAIL random_%0d: req=%b got %b want %b", i, r, obs_f(), exp_f());
                bad++;
            end
        end
    endtask

    initial begin
        RST = 1'b1;
        bus.REQ = 4'b0000;
        model_reset();
        @(negedge CLK);
        test_reset();
        test_rotation();
`ifndef RR_ARB4_TIMEOUT_EN
        test_hold();
`endif
        test_fairness();
        test_async_reset();
`ifdef RR_ARB4_TIMEOUT_EN
        test_timeout();
`endif
        test_random();
        $display("test done: total=%0d bad=%0d", total, bad);
        $finish;
    end
endmodule

// File: doc/rr_arb4.md
RR_ARB4 -- requirements
Module: rr_arb4

Interface
REQ-001 SHALL declare parameter: MAX_HOLD, 8, hold-limit cycles per grant (legal 2..15; used only with RR_ARB4_TIMEOUT_EN).
REQ-002 SHALL declare port: CLK  input  1  single clock; all state changes on rising edge.
REQ-003 SHALL declare port: RST  input  1  reset, asynchronous, active-high.
REQ-004 SHALL declare port: REQ  input  4  request per requester; bit i = requester i.
REQ-005 SHALL declare port: GNT  output  4  one-hot grant; bit i = requester i owns the shared resource.
REQ-006 SHALL declare port: GIDX  output  2  binary index of current owner; valid only while BUSY=1.
REQ-007 SHALL declare port: BUSY  output  1  high while any GNT bit is high.
REQ-008 SHALL register all outputs; no combinational path from REQ to any output.

Function
REQ-009 SHALL implement states IDLE, GRANT and, when RR_ARB4_TIMEOUT_EN is defined, RELEASE.
REQ-010 SHALL keep a 2-bit round-robin pointer PTR; search order is PTR+1, PTR+2, PTR+3, PTR (mod 4).
REQ-011 IDLE: REQ sampled nonzero at an edge -> GRANT; GNT, GIDX, BUSY take the winner at that same edge (1-cycle latency from REQ to GNT).
REQ-012 IDLE: REQ sampled 0 -> remain IDLE, GNT=0000, BUSY=0.
REQ-013 GRANT: REQ[GIDX]=1 sampled -> hold grant unchanged, regardless of other requests.
REQ-014 GRANT: REQ[GIDX]=0 sampled -> PTR<=GIDX; if other REQ bits are set, grant the next winner at that same edge (no idle gap); otherwise -> IDLE, GNT=0000.
REQ-015 A requester that drops and reasserts REQ in consecutive cycles SHALL lose priority to every other waiting requester.
REQ-016 GNT SHALL always be 0000 or exactly one-hot, and GIDX SHALL equal the index of the set bit.
REQ-017 Simultaneous requests SHALL resolve only by pointer order; with PTR=3, priority is 0,1,2,3.
REQ-018 GNT SHALL never be asserted to a requester whose REQ bit was 0 at the granting edge.

Reset
REQ-019 RST=1 SHALL immediately force state=IDLE, GNT=0000, GIDX=00, BUSY=0, PTR=11, hold counter=0, independent of CLK.
REQ-020 Reset mid-grant SHALL drop the grant without waiting for a clock edge.
REQ-021 After RST deasserts, the first arbitration SHALL occur at the first rising edge with RST=0.

Configuration
REQ-022 Macro RR_ARB4_TIMEOUT_EN SHALL compile in a hold-limit counter (4 bits), cleared on each new grant and incremented each GRANT cycle.
REQ-023 With RR_ARB4_TIMEOUT_EN, once the owner has held GNT for MAX_HOLD cycles, the next edge SHALL enter RELEASE: GNT=0000, BUSY=0, PTR<=owner, for exactly one cycle, then arbitrate as in IDLE.
REQ-024 With RR_ARB4_TIMEOUT_EN, a requester released by timeout that keeps REQ high SHALL be regranted only when it is the next winner in pointer order.
REQ-025 Without RR_ARB4_TIMEOUT_EN, no counter or RELEASE state SHALL exist, and a grant SHALL be held indefinitely while REQ[GIDX]=1.

Verification
REQ-026 Reset: RST=1 with REQ=1111 -> GNT=0000, BUSY=0, GIDX=00; release RST, next edge -> GNT=0001, GIDX=00.
REQ-027 Rotation: REQ=1111 held, each owner drops for one cycle in turn -> grant order 0,1,2,3,0 with no gap cycles.
REQ-028 Hold: REQ=0100 for 20 cycles (no timeout build) -> GNT=0100 for all 20, BUSY=1; drop REQ -> GNT=0000 next edge.
REQ-029 Fairness: owner 1 drops and re-requests immediately while REQ[3]=1 -> GNT=1000 granted before 0010.
REQ-030 Timeout (RR_ARB4_TIMEOUT_EN, MAX_HOLD=4): REQ=0011 held -> GNT=0001 for 4 cycles, 0000 for 1 cycle, then 0010 for 4 cycles.
REQ-031 Async reset: assert RST between edges during GNT=0010 -> GNT=0000 before the next edge.
